// File: rtl/gpio_ctrl.sv
// GPIO controller: synchronised and debounced inputs with edge/level interrupt
// detection and sticky status, plus register-controlled outputs with atomic set/clear.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous active-high reset
//   gpio_in  - asynchronous input pins (W_IN)
//   gpio_out - output pin register (W_OUT)
//   wr_en    - register write strobe
//   wr_addr  - register write address
//   wr_data  - write data, bits above the pin width are ignored
//   rd_en    - register read strobe
//   rd_addr  - register read address
//   rd_data  - registered read data, valid the cycle after rd_en
//   irq      - OR of (IRQ_STAT & IRQ_EN)
//
// Register map: 0 IN_STATE (RO), 1 OUT, 2 OUT_SET (WO), 3 OUT_CLR (WO),
//               4 IRQ_EN, 5 IRQ_EDGE, 6 IRQ_POL, 7 IRQ_STAT (RW1C)
module gpio_ctrl #(
  parameter int unsigned       W_IN        = 2,
  parameter int unsigned       W_OUT       = 3,
  parameter logic [W_OUT-1:0]  OUT_INIT    = '0,
  parameter logic [W_IN-1:0]   IN_INIT     = '0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       DEBOUNCE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IN-1:0]   gpio_in,
  output logic [W_OUT-1:0]  gpio_out,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [2:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic              irq
);

  localparam logic [2:0] AddrInState = 3'd0;
  localparam logic [2:0] AddrOut     = 3'd1;
  localparam logic [2:0] AddrOutSet  = 3'd2;
  localparam logic [2:0] AddrOutClr  = 3'd3;
  localparam logic [2:0] AddrIrqEn   = 3'd4;
  localparam logic [2:0] AddrIrqEdge = 3'd5;
  localparam logic [2:0] AddrIrqPol  = 3'd6;
  localparam logic [2:0] AddrIrqStat = 3'd7;

  localparam int unsigned     CntW   = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE);

  // Stage 0 samples the pins; the last stage feeds the debouncer.
  logic [SYNC_STAGES-1:0][W_IN-1:0] sync_q;
  logic [W_IN-1:0]                  sync;

  logic [W_IN-1:0]            db_q, db_d, db_prev_q;
  logic [W_IN-1:0][CntW-1:0]  cnt_q, cnt_d;

  logic [W_OUT-1:0] out_q, out_d;
  logic [W_IN-1:0]  en_q, en_d, edge_q, edge_d, pol_q, pol_d, stat_q, stat_d;
  logic [W_IN-1:0]  det, stat_clr, wr_in;
  logic [W_OUT-1:0] wr_out;
  logic [31:0]      rd_mux, rd_data_q;

  // Upper write-data bits are architecturally ignored.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign wr_in  = wr_data[W_IN-1:0];
  assign wr_out = wr_data[W_OUT-1:0];

  // Debounce: db follows sync only after DEBOUNCE+1 consecutive differing cycles.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(W_IN); i++) begin
      if (sync[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        db_d[i]  = sync[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edge detect compares current against previous debounced state.
  assign det = (edge_q & ((pol_q & db_q & ~db_prev_q) | (~pol_q & ~db_q & db_prev_q)))
             | (~edge_q & ((pol_q & db_q) | (~pol_q & ~db_q)));

  always_comb begin
    out_d    = out_q;
    en_d     = en_q;
    edge_d   = edge_q;
    pol_d    = pol_q;
    stat_clr = '0;
    if (wr_en) begin
      unique case (wr_addr)
        AddrOut:     out_d    = wr_out;
        AddrOutSet:  out_d    = out_q | wr_out;
        AddrOutClr:  out_d    = out_q & ~wr_out;
        AddrIrqEn:   en_d     = wr_in;
        AddrIrqEdge: edge_d   = wr_in;
        AddrIrqPol:  pol_d    = wr_in;
        AddrIrqStat: stat_clr = wr_in;
        default:     ;
      endcase
    end
    // A new detect event overrides a same-cycle W1C.
    stat_d = (stat_q & ~stat_clr) | det;
  end

  // Read mux uses current (pre-write) register values.
  always_comb begin
    rd_mux = '0;
    unique case (rd_addr)
      AddrInState: rd_mux[W_IN-1:0]  = db_q;
      AddrOut:     rd_mux[W_OUT-1:0] = out_q;
      AddrIrqEn:   rd_mux[W_IN-1:0]  = en_q;
      AddrIrqEdge: rd_mux[W_IN-1:0]  = edge_q;
      AddrIrqPol:  rd_mux[W_IN-1:0]  = pol_q;
      AddrIrqStat: rd_mux[W_IN-1:0]  = stat_q;
      default:     rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{IN_INIT}};
      db_q      <= IN_INIT;
      db_prev_q <= IN_INIT;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= OUT_INIT;
      en_q      <= '0;
      edge_q    <= '0;
      pol_q     <= '0;
      stat_q    <= '0;
      rd_data_q <= '0;
    end else begin
      out_q  <= out_d;
      en_q   <= en_d;
      edge_q <= edge_d;
      pol_q  <= pol_d;
      stat_q <= stat_d;
      if (rd_en) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign gpio_out = out_q;
  assign rd_data  = rd_data_q;
  assign irq      = |(stat_q & en_q);

endmodule
